wb_sequencer: RTL and testbench



---
 rtl/wb_sequencer_if.sv | 38 +++
 rtl/wb_sequencer.sv | 126 ++++++++++++
 tb/tb_wb_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// Writeback-stage bundle between the pipeline and the register-file write sequencer.
// master = pipeline/register-file side, slave = sequencer.
interface wb_sequencer_if #(
    parameter int V = 128,
    parameter int N = 32,
    parameter int M = 4
);
    localparam int L  = V / N;
    localparam int LW = (L > 1) ? $clog2(L) : 1;

    logic          regw_W;
    logic          regmem_W;
    logic          vec_W;
    logic [M-1:0]  regScr_W;
    logic [N-1:0]  ALUrslt_W;
    logic [N-1:0]  readdata_W;
    logic [V-1:0]  regVrslt_W;

    logic          stall;
    logic          sw_we;
    logic [M-1:0]  sw_addr;
    logic [N-1:0]  sw_data;
    logic          vw_we;
    logic [M-1:0]  vw_addr;
    logic [LW-1:0] vw_lane;
    logic [N-1:0]  vw_data;
    logic          vw_busy;

    modport master (
        output regw_W, regmem_W, vec_W, regScr_W, ALUrslt_W, readdata_W, regVrslt_W,
        input  stall, sw_we, sw_addr, sw_data, vw_we, vw_addr, vw_lane, vw_data, vw_busy
    );

    modport slave (
        input  regw_W, regmem_W, vec_W, regScr_W, ALUrslt_W, readdata_W, regVrslt_W,
        output stall, sw_we, sw_addr, sw_data, vw_we, vw_addr, vw_lane, vw_data, vw_busy
    );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: scalar results written combinationally, vector results captured
// and written one N-bit lane per cycle while the pipeline is stalled.
module wb_sequencer #(
    parameter int V = 128,
    parameter int N = 32,
    parameter int M = 4
) (
    input logic           clk,
    input logic           rst,
    wb_sequencer_if.slave bus
);
    localparam int L  = V / N;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(L - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_VEC  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [LW-1:0]       r_lane;
    logic [L-1:0][N-1:0] r_buf;
    logic [M-1:0]        r_addr;

    logic                w_capture;
    logic                w_last_lane;

    logic                w_stall;
    logic                w_sw_we;
    logic [M-1:0]        w_sw_addr;
    logic [N-1:0]        w_sw_data;
    logic                w_vw_we;
    logic [M-1:0]        w_vw_addr;
    logic [LW-1:0]       w_vw_lane;
    logic [N-1:0]        w_vw_data;
    logic                w_vw_busy;

    assign w_capture   = (r_state == S_IDLE) && bus.regw_W && bus.vec_W;
    assign w_last_lane = (r_lane == LAST_LANE);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state and datapath registers use non-blocking assignments so every
        // register samples pre-edge values regardless of process ordering.
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first; a missing branch
        // would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_capture)   w_next_state = S_VEC;
            S_VEC:   if (w_last_lane) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the capture buffer is reset even though it is data-only, so a
        // sequence aborted by reset never leaves stale lane data observable.
        if (!rst) begin
            r_lane <= '0;
            r_buf  <= '0;
            r_addr <= '0;
        end else if (w_capture) begin
            r_lane <= '0;
            r_buf  <= bus.regVrslt_W;
            r_addr <= bus.regScr_W;
        end else if (r_state == S_VEC) begin
            r_lane <= w_last_lane ? '0 : r_lane + LW'(1);
        end
    end

    // Outputs are forced low for as long as reset is held, not just at the edge.
    always_comb begin
        w_stall   = 1'b0;
        w_sw_we   = 1'b0;
        w_sw_addr = '0;
        w_sw_data = '0;
        w_vw_we   = 1'b0;
        w_vw_addr = '0;
        w_vw_lane = '0;
        w_vw_data = '0;
        w_vw_busy = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.regw_W) begin
                        if (bus.vec_W) begin
                            w_stall = 1'b1;
                        end else begin
                            w_sw_we   = 1'b1;
                            w_sw_addr = bus.regScr_W;
                            w_sw_data = bus.regmem_W ? bus.readdata_W : bus.ALUrslt_W;
                        end
                    end
                end
                S_VEC: begin
                    w_vw_we   = 1'b1;
                    w_vw_busy = 1'b1;
                    w_vw_addr = r_addr;
                    w_vw_lane = r_lane;
                    w_vw_data = r_buf[r_lane];
                    w_stall   = !w_last_lane;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall   = w_stall;
    assign bus.sw_we   = w_sw_we;
    assign bus.sw_addr = w_sw_addr;
    assign bus.sw_data = w_sw_data;
    assign bus.vw_we   = w_vw_we;
    assign bus.vw_addr = w_vw_addr;
    assign bus.vw_lane = w_vw_lane;
    assign bus.vw_data = w_vw_data;
    assign bus.vw_busy = w_vw_busy;
endmodule

// File: tb/tb_wb_sequencer.sv
// Testbench for wb_sequencer: directed scenarios plus random instruction streams,
// checked against a queue-of-pending-lane-writes reference model.
module tb_wb_sequencer;
    localparam int V  = 128;
    localparam int N  = 32;
    localparam int M  = 4;
    localparam int L  = V / N;
    localparam int LW = (L > 1) ? $clog2(L) : 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_sequencer_if #(.V(V), .N(N), .M(M)) bus ();

    wb_sequencer #(.V(V), .N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [M-1:0]  addr;
        logic [LW-1:0] lane;
        logic [N-1:0]  data;
    } beat_t;

    beat_t pending[$];

    logic          obs_stall;
    logic          obs_vw_we;
    logic [M-1:0]  obs_vw_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic regw, input logic vec, input logic regmem,
                         input logic [M-1:0] idx, input logic [N-1:0] alu,
                         input logic [N-1:0] rd, input logic [V-1:0] vr);
        bus.regw_W     = regw;
        bus.vec_W      = vec;
        bus.regmem_W   = regmem;
        bus.regScr_W   = idx;
        bus.ALUrslt_W  = alu;
        bus.readdata_W = rd;
        bus.regVrslt_W = vr;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, ".stall"},   64'(bus.stall),   64'd0);
        check({pfx, ".sw_we"},   64'(bus.sw_we),   64'd0);
        check({pfx, ".sw_addr"}, 64'(bus.sw_addr), 64'd0);
        check({pfx, ".sw_data"}, 64'(bus.sw_data), 64'd0);
        check({pfx, ".vw_we"},   64'(bus.vw_we),   64'd0);
        check({pfx, ".vw_addr"}, 64'(bus.vw_addr), 64'd0);
        check({pfx, ".vw_lane"}, 64'(bus.vw_lane), 64'd0);
        check({pfx, ".vw_data"}, 64'(bus.vw_data), 64'd0);
        check({pfx, ".vw_busy"}, 64'(bus.vw_busy), 64'd0);
    endtask

    // Expected outputs: a pending lane write wins; otherwise the current instruction decides.
    task automatic check_outputs(input string pfx);
        logic          e_stall   = 1'b0;
        logic          e_sw_we   = 1'b0;
        logic [M-1:0]  e_sw_addr = '0;
        logic [N-1:0]  e_sw_data = '0;
        logic          e_vw_we   = 1'b0;
        logic [M-1:0]  e_vw_addr = '0;
        logic [LW-1:0] e_vw_lane = '0;
        logic [N-1:0]  e_vw_data = '0;
        logic          e_vw_busy = 1'b0;
        if (pending.size() > 0) begin
            e_vw_we   = 1'b1;
            e_vw_busy = 1'b1;
            e_vw_addr = pending[0].addr;
            e_vw_lane = pending[0].lane;
            e_vw_data = pending[0].data;
            e_stall   = (pending.size() > 1);
        end else if (bus.regw_W && bus.vec_W) begin
            e_stall = 1'b1;
        end else if (bus.regw_W) begin
            e_sw_we   = 1'b1;
            e_sw_addr = bus.regScr_W;
            e_sw_data = bus.regmem_W ? bus.readdata_W : bus.ALUrslt_W;
        end
        check({pfx, ".stall"},   64'(bus.stall),   64'(e_stall));
        check({pfx, ".sw_we"},   64'(bus.sw_we),   64'(e_sw_we));
        check({pfx, ".sw_addr"}, 64'(bus.sw_addr), 64'(e_sw_addr));
        check({pfx, ".sw_data"}, 64'(bus.sw_data), 64'(e_sw_data));
        check({pfx, ".vw_we"},   64'(bus.vw_we),   64'(e_vw_we));
        check({pfx, ".vw_addr"}, 64'(bus.vw_addr), 64'(e_vw_addr));
        check({pfx, ".vw_lane"}, 64'(bus.vw_lane), 64'(e_vw_lane));
        check({pfx, ".vw_data"}, 64'(bus.vw_data), 64'(e_vw_data));
        check({pfx, ".vw_busy"}, 64'(bus.vw_busy), 64'(e_vw_busy));
    endtask

    // One clock: check at the falling edge, update the model, resume just after the rising edge.
    task automatic cycle(input string pfx);
        beat_t b;
        @(negedge clk);
        check_outputs(pfx);
        obs_stall   = bus.stall;
        obs_vw_we   = bus.vw_we;
        obs_vw_addr = bus.vw_addr;
        if (pending.size() > 0) begin
            void'(pending.pop_front());
        end else if (bus.regw_W && bus.vec_W) begin
            for (int i = 0; i < L; i++) begin
                b.addr = bus.regScr_W;
                b.lane = LW'(i);
                b.data = bus.regVrslt_W[i*N +: N];
                pending.push_back(b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [V-1:0] rand_vec();
        logic [V-1:0] v;
        for (int i = 0; i < V / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [V-1:0] vpat;
        int           count;
        int           beats2;
        int           beats9;
        bit           done;

        // Reset: outputs forced low even with a live scalar write presented.
        drive(1'b1, 1'b0, 1'b0, 4'd3, 32'hCAFEF00D, 32'h0, '0);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Scalar ALU and load writes.
        drive(1'b1, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 32'h0, '0);
        cycle("scalar_alu");
        drive(1'b1, 1'b0, 1'b1, 4'd7, 32'hFFFFFFFF, 32'h12345678, '0);
        cycle("scalar_load");

        // Single vector write, held while stalled.
        vpat = 128'h44444444_33333333_22222222_11111111;
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 32'h0, vpat);
        for (int c = 0; c < L + 1; c++) cycle($sformatf("vec_c%0d", c));
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, '0);
        cycle("vec_after");

        // Back-to-back vectors; second instruction appears while the first is stalled.
        drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h0, 32'h0, rand_vec());
        cycle("b2b_cap");
        count  = 1;
        beats2 = 0;
        beats9 = 0;
        done   = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd9, 32'h55555555, 32'hAAAAAAAA, rand_vec());
        for (int c = 0; c < 20 && !done; c++) begin
            cycle("b2b");
            count++;
            if (obs_vw_we && obs_vw_addr == 4'd2) beats2++;
            if (obs_vw_we && obs_vw_addr == 4'd9) beats9++;
            if (obs_vw_we && !obs_stall && obs_vw_addr == 4'd9) done = 1'b1;
        end
        check("b2b_cycles", 64'(count), 64'(2 * (L + 1)));
        check("b2b_beats_v2", 64'(beats2), 64'(L));
        check("b2b_beats_v9", 64'(beats9), 64'(L));
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, '0);
        cycle("b2b_after");

        // Asynchronous reset while lane 1 is being written.
        drive(1'b1, 1'b1, 1'b0, 4'd6, 32'h0, 32'h0, rand_vec());
        cycle("rst_cap");
        cycle("rst_lane0");
        check("rst_pre_lane", 64'(bus.vw_lane), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        pending.delete();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, '0);
        #1;
        rst = 1'b1;
        for (int c = 0; c < L; c++) cycle("rst_after");

        // Non-writing instruction with vec_W set must not start a sequence.
        drive(1'b0, 1'b1, 1'b1, 4'd11, 32'h1, 32'h2, rand_vec());
        cycle("nowrite");
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, '0);
        cycle("nowrite_after");

        // Random instruction stream; inputs may change even while stalled.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
                  M'($urandom), $urandom, $urandom, rand_vec());
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
